ascon_permutation_iter: RTL and testbench
=========================================

Name: ascon_permutation_iter

Overview:
- Parametrised successor to the single-round Ascon permutation datapath.
- Runs a complete Ascon permutation p^a (12 rounds), p^b (6 rounds) or the Ascon-128a p^b (8 rounds) autonomously after a start pulse.
- Owns an internal round counter, round-constant sequencing and a start/busy/done handshake.
- The future mode FSM drives only start/rounds; it no longer steps round_i itself.

Parameters:
- ROUNDS_PER_CYCLE, default 1: unrolled rounds per clock. Legal values are 1 and 2; elaboration error otherwise.

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request a permutation; sampled only in IDLE.
- nr_i  input  4  number of rounds: 12, 8 or 6. Any other value is treated as 12.
- state_i  input  320 (type_state, 5x64)  permutation input; sampled with start_i.
- state_o  output  320 (type_state)  working/result register.
- busy_o  output  1  permutation in progress.
- done_o  output  1  one-cycle pulse; state_o holds the final result.

Behaviour:
- Reset (reset_i=0, asynchronous): FSM=IDLE, state_o=0, busy_o=0, done_o=0, round counter=0.
- Reset mid-run aborts immediately; no done_o is produced.
- Round index r runs from 12-nr to 11. Round constant c_r = ((15-r)<<4)|r, XORed into x2 (r=0 gives 0xF0, r=11 gives 0x4B).
- Each round applies, in order: constant addition, 5-bit S-box layer, linear layer.
  - x0 ^= x0>>>19 ^ x0>>>28
  - x1 ^= >>>61 ^ >>>39
  - x2 ^= >>>1 ^ >>>6
  - x3 ^= >>>10 ^ >>>17
  - x4 ^= >>>7 ^ >>>41
- N = nr/ROUNDS_PER_CYCLE clock cycles per permutation.
- FSM states:
  - IDLE: on start_i=1 at edge E0:
    - state_o <= ROUNDS_PER_CYCLE rounds applied to state_i, starting at r=12-nr.
    - Counter advances by ROUNDS_PER_CYCLE.
    - If N=1 go to DONE, else go to RUN with busy_o=1.
  - RUN: each edge applies the next ROUNDS_PER_CYCLE rounds to state_o. On the edge that completes r=11, go to DONE.
  - DONE: done_o=1 and busy_o=0 for exactly one cycle; unconditionally return to IDLE.
- Latency: done_o is high in the cycle following edge E(N-1).
  - ROUNDS_PER_CYCLE=1: 12 cycles for nr=12, 6 cycles for nr=6.
- state_o holds its value after DONE until the next accepted start.
- start_i while in RUN or DONE is ignored, not queued.
- nr_i and state_i are don't-care outside the start edge.
- A start may be accepted in the cycle after DONE (IDLE), giving back-to-back operation with one idle bubble.

Optional Feature:
- Macro ASCON_PERM_XOR_IN_EN.
- When defined:
  - Adds input port xor_i (type_state).
  - At start acceptance, the first round operates on state_i ^ xor_i. This is the data absorption / key XOR for the mode FSM.
- When undefined:
  - Port xor_i is absent.
  - The first round operates on state_i directly.
- Cycle timing is identical in both cases.

Decomposition:
- ascon_pack holds:
  - type_state
  - round-constant function rc(r)
  - constants NR_A=12, NR_B=6, NR_B128A=8
  - 5-bit S-box function
- One sub-module, ascon_round: purely combinational single round with round index input.
  - Instantiated ROUNDS_PER_CYCLE times in a chain.
  - The top owns the FSM, counter and register.

Test Plan:
- Ascon-128 init vector: state_i = {80400c0600000000, 0001020304050607, 08090a0b0c0d0e0f, 0011223344556677, 8899aabbccddeeff}, nr=12, RPC=1.
  - done_o high exactly 12 cycles after the start edge.
  - state_o equals the golden C-model p^12 output, bit-exact.
- Same state_i with nr=6 and nr=8.
  - done_o after 6 and 8 cycles respectively.
  - Constants used: 0x96..0x4B for nr=6, and 0xB4..0x4B for nr=8.
  - Results match the golden model.
- RPC=2, nr=12 on the init vector.
  - done after 6 cycles.
  - state_o identical to the RPC=1 result.
- start_i pulsed again at cycles 3 and 7 of a run.
  - Ignored; result and done timing unchanged.
  - Then a start in the cycle after done is accepted.
- reset_i driven low at cycle 5 of a 12-round run.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - No done_o follows.
  - A fresh start after reset release produces the correct result.
- nr_i=4'd5 (illegal) behaves exactly as nr=12.
  - With ASCON_PERM_XOR_IN_EN and xor_i=state_i, the input becomes all-zero and the result matches golden p^12(0).

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and helpers for the iterative Ascon permutation: state layout,
// round constants, round-count constants, the 5-bit S-box and a 64-bit rotate.
package ascon_pack;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  localparam logic [3:0] NR_A     = 4'd12;
  localparam logic [3:0] NR_B     = 4'd6;
  localparam logic [3:0] NR_B128A = 4'd8;

  // Column input is {x0,x1,x2,x3,x4} with x0 in the MSB.
  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  function automatic logic [4:0] sbox(input logic [4:0] x);
    return SBOX_TABLE[x];
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One purely combinational Ascon round: constant addition, S-box layer and
// linear diffusion layer, selected by the round index.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  din,
  input  logic [3:0] round_idx,
  output type_state  dout
);

  type_state added;
  type_state subbed;

  always_comb begin
    added    = din;
    added.x2 = din.x2 ^ {56'd0, rc(round_idx)};
  end

  // The S-box works on bit-columns: bit j of each of the five words.
  always_comb begin
    subbed = added;
    for (int j = 0; j < 64; j++) begin
      {subbed.x0[j], subbed.x1[j], subbed.x2[j], subbed.x3[j], subbed.x4[j]} =
        sbox({added.x0[j], added.x1[j], added.x2[j], added.x3[j], added.x4[j]});
    end
  end

  always_comb begin
    dout    = subbed;
    dout.x0 = subbed.x0 ^ ror64(subbed.x0, 19) ^ ror64(subbed.x0, 28);
    dout.x1 = subbed.x1 ^ ror64(subbed.x1, 61) ^ ror64(subbed.x1, 39);
    dout.x2 = subbed.x2 ^ ror64(subbed.x2, 1)  ^ ror64(subbed.x2, 6);
    dout.x3 = subbed.x3 ^ ror64(subbed.x3, 10) ^ ror64(subbed.x3, 17);
    dout.x4 = subbed.x4 ^ ror64(subbed.x4, 7)  ^ ror64(subbed.x4, 41);
  end

endmodule

// File: rtl/ascon_permutation_iter.sv
// Autonomous Ascon permutation (12, 8 or 6 rounds) with start/busy/done handshake.
// Optional ASCON_PERM_XOR_IN_EN adds xor_i, folded into state_i at start acceptance.
module ascon_permutation_iter
  import ascon_pack::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
)
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] nr_i,
  input  type_state  state_i,
`ifdef ASCON_PERM_XOR_IN_EN
  input  type_state  xor_i,
`endif
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
    $error("ascon_permutation_iter: ROUNDS_PER_CYCLE must be 1 or 2");
  end

  localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t     fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  type_state  data_q, data_d;

  logic [3:0] nr_eff;
  logic [3:0] first_r;
  type_state  in_state;
  type_state  chain_in;
  logic [3:0] chain_base;
  logic [3:0] rnd_sum;
  type_state  chain [ROUNDS_PER_CYCLE+1];

  assign nr_eff  = (nr_i == NR_B || nr_i == NR_B128A) ? nr_i : NR_A;
  assign first_r = NR_A - nr_eff;

`ifdef ASCON_PERM_XOR_IN_EN
  assign in_state = state_i ^ xor_i;
`else
  assign in_state = state_i;
`endif

  // In IDLE the round chain looks at the incoming state, otherwise at the register.
  always_comb begin
    chain_in   = data_q;
    chain_base = rnd_q;
    if (fsm_q == ST_IDLE) begin
      chain_in   = in_state;
      chain_base = first_r;
    end
  end

  assign chain[0] = chain_in;
  assign rnd_sum  = chain_base + RPC;

  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    ascon_round u_round (
      .din       (chain[i]),
      .round_idx (chain_base + 4'(i)),
      .dout      (chain[i+1])
    );
  end

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    data_d = data_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          data_d = chain[ROUNDS_PER_CYCLE];
          rnd_d  = rnd_sum;
          fsm_d  = (rnd_sum >= NR_A) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        data_d = chain[ROUNDS_PER_CYCLE];
        rnd_d  = rnd_sum;
        if (rnd_sum >= NR_A) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
        rnd_d = 4'd0;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      fsm_q  <= ST_IDLE;
      rnd_q  <= 4'd0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
    end
  end

  assign state_o = data_q;
  assign busy_o  = (fsm_q == ST_RUN);
  assign done_o  = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Bench for ascon_permutation_iter: one RPC=1 and one RPC=2 instance checked
// against a bit-sliced reference permutation.
module tb_ascon_permutation_iter;

  localparam logic [319:0] IV = {64'h80400c0600000000, 64'h0001020304050607,
                                 64'h08090a0b0c0d0e0f, 64'h0011223344556677,
                                 64'h8899aabbccddeeff};
  localparam logic [319:0] VEC2 = {64'hdeadbeefcafef00d, 64'h0123456789abcdef,
                                   64'hffffffff00000000, 64'h5555aaaa5555aaaa,
                                   64'h0f1e2d3c4b5a6978};

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start1 = 1'b0;
  logic         start2 = 1'b0;
  logic [3:0]   nr_in = 4'd12;
  logic [319:0] state_in = '0;
  logic [319:0] state1, state2;
  logic         busy1, busy2, done1, done2;
`ifdef ASCON_PERM_XOR_IN_EN
  logic [319:0] xor_in = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ascon_permutation_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clock_i (clock),
    .reset_i (reset_n),
    .start_i (start1),
    .nr_i    (nr_in),
    .state_i (state_in),
`ifdef ASCON_PERM_XOR_IN_EN
    .xor_i   (xor_in),
`endif
    .state_o (state1),
    .busy_o  (busy1),
    .done_o  (done1)
  );

  ascon_permutation_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (
    .clock_i (clock),
    .reset_i (reset_n),
    .start_i (start2),
    .nr_i    (nr_in),
    .state_i (state_in),
`ifdef ASCON_PERM_XOR_IN_EN
    .xor_i   (xor_in),
`endif
    .state_o (state2),
    .busy_o  (busy2),
    .done_o  (done2)
  );

  // Reference permutation written in the bit-sliced instruction form.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 12 - nr; r < 12; r++) begin
      x2 = x2 ^ {56'd0, 4'(15 - r), 4'(r)};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
      x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the selected DUT idle; returns #1 after the
  // edge that brings it back to IDLE. Extra start pulses at cycles pa/pb.
  task automatic applyStimulus(input string tag, input int unit, input logic [3:0] nr,
                               input logic [319:0] s, input int pa, input int pb);
    int nr_eff, exp_n, cyc;
    bit seen;
    logic [319:0] exp;
    nr_eff = (nr == 4'd6 || nr == 4'd8) ? int'(nr) : 12;
    exp_n  = nr_eff / unit;
`ifdef ASCON_PERM_XOR_IN_EN
    exp = model_perm(s ^ xor_in, nr_eff);
`else
    exp = model_perm(s, nr_eff);
`endif
    nr_in = nr;
    state_in = s;
    if (unit == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0; start2 = 1'b0;
    nr_in = 4'd0; state_in = '1;
    if (exp_n > 1) checkOutput({tag, " busy"}, (unit == 1) ? busy1 : busy2, 1);
    cyc = 1; seen = 0;
    while (cyc <= 40 && !seen) begin
      if ((unit == 1) ? done1 : done2) seen = 1;
      else begin
        if (cyc == pa || cyc == pb) begin
          if (unit == 1) start1 = 1'b1; else start2 = 1'b1;
        end
        @(posedge clock); #1;
        start1 = 1'b0; start2 = 1'b0;
        cyc++;
      end
    end
    checkOutput({tag, " latency"}, cyc, exp_n);
    checkOutput({tag, " result"}, (unit == 1) ? state1 : state2, exp);
    checkOutput({tag, " busy at done"}, (unit == 1) ? busy1 : busy2, 0);
    @(posedge clock); #1;
    checkOutput({tag, " done pulse"}, (unit == 1) ? done1 : done2, 0);
    checkOutput({tag, " hold"}, (unit == 1) ? state1 : state2, exp);
  endtask

  initial begin
    int done_cnt;
    #1;
    checkOutput("reset state1", state1, 0);
    checkOutput("reset busy1", busy1, 0);
    checkOutput("reset done1", done1, 0);
    checkOutput("reset state2", state2, 0);
    checkOutput("reset busy2", busy2, 0);
    checkOutput("reset done2", done2, 0);
    #11 reset_n = 1'b1;
    @(posedge clock); #1;

    applyStimulus("rpc1 p12", 1, 4'd12, IV, 0, 0);
    applyStimulus("rpc1 p6", 1, 4'd6, IV, 0, 0);
    applyStimulus("rpc1 p8", 1, 4'd8, IV, 0, 0);
    applyStimulus("rpc2 p12", 2, 4'd12, IV, 0, 0);
    applyStimulus("rpc2 p6", 2, 4'd6, IV, 0, 0);
    applyStimulus("rpc2 p8", 2, 4'd8, VEC2, 0, 0);

    applyStimulus("ignored starts", 1, 4'd12, VEC2, 3, 7);
    applyStimulus("back to back", 1, 4'd6, VEC2, 0, 0);

    nr_in = 4'd12;
    state_in = IV;
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clock);
    #4 reset_n = 1'b0;
    #1;
    checkOutput("abort state", state1, 0);
    checkOutput("abort busy", busy1, 0);
    checkOutput("abort done", done1, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done1) done_cnt++;
    end
    checkOutput("no done after abort", done_cnt, 0);
    applyStimulus("after reset", 1, 4'd12, IV, 0, 0);

    applyStimulus("illegal nr rpc1", 1, 4'd5, IV, 0, 0);
    applyStimulus("illegal nr rpc2", 2, 4'd5, VEC2, 0, 0);

`ifdef ASCON_PERM_XOR_IN_EN
    xor_in = IV;
    applyStimulus("xor zero input", 1, 4'd12, IV, 0, 0);
    checkOutput("xor golden zero", state1, model_perm('0, 12));
    xor_in = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
